// File: rtl/instruction_fetch.sv
//==============================================================================
// Module      : instruction_fetch
// Description : Fetch sequencer between the instruction pointer, instruction
//               memory and decode. Issues one read per instruction, detects
//               16-bit (compressed) vs 32-bit encodings, tells the pointer how
//               far to advance, and presents the result on a valid/ready port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instruction_fetch (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [31:0] i_Address,
  output logic        o_Stride,
  output logic        o_Stall,
  output logic        o_MemRequest,
  output logic [31:0] o_MemAddress,
  input  logic        i_MemValid,
  input  logic [31:0] i_MemData,
  output logic        o_Valid,
  input  logic        i_Ready,
  output logic [31:0] o_Instruction,
  output logic [31:0] o_ProgramCounter,
  output logic        o_Compressed,
  input  logic        i_Flush,
  output logic        o_Fault,
  output logic [15:0] o_FetchCount
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t      r_State;
  state_t      w_NextState;
  logic        w_Capture;
  logic        w_Handshake;
  logic        w_Release;
  logic        w_Misaligned;
  logic        w_IsCompressed;
  logic        r_Valid;
  logic        r_Compressed;
  logic        r_Fault;
  logic [31:0] r_Instruction;
  logic [31:0] r_ProgramCounter;
  logic [15:0] r_FetchCount;

  // Any encoding whose low two bits are not 2'b11 is a 16-bit instruction.
  assign w_IsCompressed = (i_MemData[1:0] != 2'b11);

  // Next-state decode plus the combinational strobes to pointer and memory.
  always_comb begin
    w_NextState  = r_State;
    o_MemRequest = 1'b0;
    o_MemAddress = 32'h0;
    o_Stall      = 1'b1;
    o_Stride     = 1'b0;
    w_Capture    = 1'b0;
    w_Handshake  = 1'b0;
    w_Release    = 1'b0;
    w_Misaligned = 1'b0;
    case (r_State)
      IDLE: w_NextState = REQ;
      REQ: begin
        // A flush means the pointer is being reloaded this cycle, so the
        // address seen now is stale; wait one cycle and sample again.
        if (i_Flush) begin
          w_NextState = REQ;
        end else if (i_Address[0]) begin
          w_Misaligned = 1'b1;
          w_NextState  = FAULT;
        end else begin
          o_MemRequest = 1'b1;
          o_MemAddress = i_Address;
          w_NextState  = WAIT;
        end
      end
      WAIT: begin
        if (i_Flush) begin
          // A response in the flush cycle is dropped on the spot; otherwise
          // the in-flight response must still be absorbed in DRAIN.
          w_NextState = i_MemValid ? REQ : DRAIN;
        end else if (i_MemValid) begin
          w_Capture   = 1'b1;
          o_Stall     = 1'b0;
          o_Stride    = ~w_IsCompressed;
          w_NextState = HOLD;
        end
      end
      DRAIN: begin
        if (i_MemValid) begin
          w_NextState = REQ;
        end
      end
      HOLD: begin
        if (i_Flush) begin
          w_Release   = 1'b1;
          w_NextState = REQ;
        end else if (i_Ready) begin
          w_Release   = 1'b1;
          w_Handshake = 1'b1;
          w_NextState = REQ;
        end
      end
      FAULT: begin
        if (i_Flush) begin
          w_NextState = REQ;
        end
      end
      default: w_NextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State <= IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  // Output payload, sticky fault flag and delivered-instruction counter.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Valid          <= 1'b0;
      r_Compressed     <= 1'b0;
      r_Fault          <= 1'b0;
      r_Instruction    <= 32'h0;
      r_ProgramCounter <= 32'h0;
      r_FetchCount     <= 16'h0;
    end else begin
      if (o_MemRequest) begin
        r_ProgramCounter <= i_Address;
      end
      if (w_Capture) begin
        r_Valid       <= 1'b1;
        r_Compressed  <= w_IsCompressed;
        r_Instruction <= w_IsCompressed ? {16'h0, i_MemData[15:0]} : i_MemData;
      end else if (w_Release) begin
        r_Valid <= 1'b0;
      end
      if (w_Handshake) begin
        r_FetchCount <= r_FetchCount + 16'd1;
      end
      if (w_Misaligned) begin
        r_Fault <= 1'b1;
      end else if (r_State == FAULT && i_Flush) begin
        r_Fault <= 1'b0;
      end
    end
  end

  assign o_Valid          = r_Valid;
  assign o_Compressed     = r_Compressed;
  assign o_Fault          = r_Fault;
  assign o_Instruction    = r_Instruction;
  assign o_ProgramCounter = r_ProgramCounter;
  assign o_FetchCount     = r_FetchCount;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
//==============================================================================
// Module      : tb_instruction_fetch
// Description : Testbench for instruction_fetch. Models the instruction
//               pointer and a fixed-latency instruction memory; expected
//               deliveries are queued when memory answers and checked when
//               decode accepts them.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instruction_fetch;

  logic        Clock;
  logic        i_Reset;
  logic [31:0] i_Address;
  logic        o_Stride;
  logic        o_Stall;
  logic        o_MemRequest;
  logic [31:0] o_MemAddress;
  logic        i_MemValid;
  logic [31:0] i_MemData;
  logic        o_Valid;
  logic        i_Ready;
  logic [31:0] o_Instruction;
  logic [31:0] o_ProgramCounter;
  logic        o_Compressed;
  logic        i_Flush;
  logic        o_Fault;
  logic [15:0] o_FetchCount;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
  } exp_t;

  int          assertions;
  int          failures;
  int          cycle;
  int          latency;
  int          pendRem;
  logic        pend;
  logic        pendStale;
  logic        curStale;
  logic [31:0] ptr;
  logic [31:0] flushTarget;
  logic [31:0] pendAddr;
  logic [31:0] curAddr;
  logic [15:0] expCount;
  logic [31:0] memWords [logic [31:0]];
  exp_t        expQ [$];

  instruction_fetch dut (
    .i_Clock          (Clock),
    .i_Reset          (i_Reset),
    .i_Address        (i_Address),
    .o_Stride         (o_Stride),
    .o_Stall          (o_Stall),
    .o_MemRequest     (o_MemRequest),
    .o_MemAddress     (o_MemAddress),
    .i_MemValid       (i_MemValid),
    .i_MemData        (i_MemData),
    .o_Valid          (o_Valid),
    .i_Ready          (i_Ready),
    .o_Instruction    (o_Instruction),
    .o_ProgramCounter (o_ProgramCounter),
    .o_Compressed     (o_Compressed),
    .i_Flush          (i_Flush),
    .o_Fault          (o_Fault),
    .o_FetchCount     (o_FetchCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory contents: explicit words where placed, else a 32-bit encoding.
  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memWords.exists(a)) return memWords[a];
    return {a[15:0] ^ 16'hA5C3, a[15:2], 2'b11};
  endfunction

  function automatic exp_t mkExp(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.pc    = a;
    e.comp  = (d[1:0] != 2'b11);
    e.instr = e.comp ? {16'h0, d[15:0]} : d;
    return e;
  endfunction

  // One clock cycle of environment: sample, edge, then update pointer/memory.
  task automatic tick();
    logic        sReq, sStall, sStride, sFlush, sReset, sHs, sDrop;
    logic [31:0] sAddr;
    exp_t        e;
    #1;
    sReq    = o_MemRequest;
    sAddr   = o_MemAddress;
    sStall  = o_Stall;
    sStride = o_Stride;
    sFlush  = i_Flush;
    sReset  = i_Reset;
    sHs     = (o_Valid === 1'b1) && i_Ready && !i_Flush && !i_Reset;
    sDrop   = (o_Valid === 1'b1) && i_Flush && !i_Reset;
    if (sReq === 1'b1 && !sReset) begin
      assertions++;
      if (pend) begin
        failures++;
        $display("FAIL single_outstanding: request to %h while %h still pending", sAddr, pendAddr);
      end
    end
    if (i_MemValid && !curStale && !sFlush && !sReset) expQ.push_back(mkExp(curAddr, i_MemData));
    if (sHs) begin
      assertions++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: delivered pc=%h instr=%h, required no delivery", o_ProgramCounter, o_Instruction);
      end else begin
        e = expQ.pop_front();
        if ({o_ProgramCounter, o_Instruction, o_Compressed} !== {e.pc, e.instr, e.comp}) begin
          failures++;
          $display("FAIL scoreboard_payload: got pc=%h instr=%h c=%b, required pc=%h instr=%h c=%b",
                   o_ProgramCounter, o_Instruction, o_Compressed, e.pc, e.instr, e.comp);
        end
      end
      expCount = expCount + 16'd1;
    end
    if (sDrop && expQ.size() > 0) void'(expQ.pop_front());

    @(posedge Clock);
    #1;
    cycle++;
    if (sHs) begin
      assertions++;
      if (o_FetchCount !== expCount) begin
        failures++;
        $display("FAIL fetch_count: got %h required %h", o_FetchCount, expCount);
      end
    end
    if (sReset) begin
      expQ.delete();
      expCount = 16'h0;
      if (pend) pendStale = 1'b1;
    end else if (sFlush) begin
      ptr = flushTarget;
      if (pend) pendStale = 1'b1;
    end else if (sStall === 1'b0) begin
      ptr = ptr + ((sStride === 1'b1) ? 32'd4 : 32'd2);
    end
    i_Flush    = 1'b0;
    i_Reset    = 1'b0;
    i_MemValid = 1'b0;
    curStale   = 1'b0;
    if (sReq === 1'b1) begin
      pend      = 1'b1;
      pendStale = sReset;
      pendAddr  = sAddr;
      pendRem   = latency;
    end
    if (pend) begin
      pendRem--;
      if (pendRem <= 0) begin
        i_MemValid = 1'b1;
        i_MemData  = memRead(pendAddr);
        curAddr    = pendAddr;
        curStale   = pendStale;
        pend       = 1'b0;
      end
    end
    i_Address = ptr;
    #1;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    tick();
    assertions++; if (o_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", o_Valid); end
    assertions++; if (o_MemRequest !== 1'b0) begin failures++; $display("FAIL reset_memreq: got %b required 0", o_MemRequest); end
    assertions++; if (o_Fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b required 0", o_Fault); end
    assertions++; if (o_Compressed !== 1'b0) begin failures++; $display("FAIL reset_compressed: got %b required 0", o_Compressed); end
    assertions++; if (o_Stride !== 1'b0) begin failures++; $display("FAIL reset_stride: got %b required 0", o_Stride); end
    assertions++; if (o_Stall !== 1'b1) begin failures++; $display("FAIL reset_stall: got %b required 1", o_Stall); end
    assertions++; if (o_Instruction !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h required 0", o_Instruction); end
    assertions++; if (o_ProgramCounter !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h required 0", o_ProgramCounter); end
    assertions++; if (o_MemAddress !== 32'h0) begin failures++; $display("FAIL reset_memaddr: got %h required 0", o_MemAddress); end
    assertions++; if (o_FetchCount !== 16'h0) begin failures++; $display("FAIL reset_count: got %h required 0", o_FetchCount); end
  endtask

  task automatic test_basic();
    int firstReq;
    tick();
    firstReq = cycle;
    assertions++; if ({o_MemRequest, o_MemAddress} !== {1'b1, 32'h0040_0000}) begin failures++; $display("FAIL basic_req: got %b/%h required 1/00400000", o_MemRequest, o_MemAddress); end
    tick();
    assertions++; if ({o_Stall, o_Stride} !== 2'b01) begin failures++; $display("FAIL basic_advance: got stall=%b stride=%b required stall=0 stride=1", o_Stall, o_Stride); end
    tick();
    assertions++; if ({o_Valid, o_Compressed} !== 2'b10) begin failures++; $display("FAIL basic_valid: got v=%b c=%b required v=1 c=0", o_Valid, o_Compressed); end
    assertions++; if ({o_ProgramCounter, o_Instruction} !== {32'h0040_0000, 32'h0000_0513}) begin failures++; $display("FAIL basic_payload: got %h/%h required 00400000/00000513", o_ProgramCounter, o_Instruction); end
    tick();
    assertions++; if ({o_MemRequest, o_MemAddress} !== {1'b1, 32'h0040_0004}) begin failures++; $display("FAIL basic_next_req: got %b/%h required 1/00400004", o_MemRequest, o_MemAddress); end
    assertions++; if (cycle - firstReq !== 3) begin failures++; $display("FAIL basic_throughput: got %0d cycles required 3", cycle - firstReq); end
  endtask

  task automatic test_compressed();
    tick();
    assertions++; if ({o_Stall, o_Stride} !== 2'b00) begin failures++; $display("FAIL comp_advance: got stall=%b stride=%b required stall=0 stride=0", o_Stall, o_Stride); end
    tick();
    assertions++; if ({o_Valid, o_Compressed, o_Instruction} !== {2'b11, 32'h0000_4501}) begin failures++; $display("FAIL comp_payload: got v=%b c=%b %h required v=1 c=1 00004501", o_Valid, o_Compressed, o_Instruction); end
    tick();
    assertions++; if ({o_MemRequest, o_MemAddress} !== {1'b1, 32'h0040_0006}) begin failures++; $display("FAIL comp_next_req: got %b/%h required 1/00400006", o_MemRequest, o_MemAddress); end
    assertions++; if (o_FetchCount !== 16'd2) begin failures++; $display("FAIL comp_count: got %0d required 2", o_FetchCount); end
  endtask

  task automatic test_hold_stall();
    exp_t held;
    i_Ready = 1'b0;
    tick();
    tick();
    held = mkExp(32'h0040_0006, memRead(32'h0040_0006));
    for (int i = 0; i < 5; i++) begin
      assertions++;
      if ({o_Valid, o_ProgramCounter, o_Instruction, o_Compressed} !== {1'b1, held.pc, held.instr, held.comp}) begin
        failures++;
        $display("FAIL hold_payload[%0d]: got v=%b %h/%h required v=1 %h/%h", i, o_Valid, o_ProgramCounter, o_Instruction, held.pc, held.instr);
      end
      assertions++;
      if ({o_Stall, o_MemRequest, o_FetchCount} !== {2'b10, 16'd2}) begin
        failures++;
        $display("FAIL hold_quiet[%0d]: got stall=%b req=%b count=%0d required 1/0/2", i, o_Stall, o_MemRequest, o_FetchCount);
      end
      tick();
    end
    i_Ready = 1'b1;
    tick();
    assertions++; if ({o_Valid, o_FetchCount} !== {1'b0, 16'd3}) begin failures++; $display("FAIL hold_release: got v=%b count=%0d required 0/3", o_Valid, o_FetchCount); end
  endtask

  task automatic test_flush_wait();
    logic got, advanced;
    latency = 3;
    assertions++; if ({o_MemRequest, o_MemAddress} !== {1'b1, 32'h0040_000A}) begin failures++; $display("FAIL flush_pre_req: got %b/%h required 1/0040000a", o_MemRequest, o_MemAddress); end
    tick();
    i_Flush = 1'b1;
    flushTarget = 32'hFEED_FACE;
    tick();
    got = 1'b0;
    advanced = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (o_MemRequest === 1'b1) got = 1'b1;
      else begin
        if (o_Stall !== 1'b1 || o_Valid !== 1'b0) advanced = 1'b1;
        tick();
      end
    end
    assertions++; if (!got) begin failures++; $display("FAIL flush_timeout: got no request required request within 10 cycles"); end
    assertions++; if (advanced) begin failures++; $display("FAIL flush_stale: got advance/valid while draining required none"); end
    assertions++; if (o_MemAddress !== 32'hFEED_FACE) begin failures++; $display("FAIL flush_redirect: got %h required feedface", o_MemAddress); end
    tick();
    tick();
    tick();
    i_Flush = 1'b1;
    flushTarget = 32'h0000_2000;
    #1;
    assertions++; if (o_Stall !== 1'b1) begin failures++; $display("FAIL flush_resp_stall: got %b required 1", o_Stall); end
    tick();
    assertions++; if ({o_Valid, o_MemRequest, o_MemAddress} !== {2'b01, 32'h0000_2000}) begin failures++; $display("FAIL flush_resp_redirect: got v=%b req=%b %h required 0/1/00002000", o_Valid, o_MemRequest, o_MemAddress); end
  endtask

  task automatic test_fault();
    logic got;
    latency = 1;
    i_Ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (o_Valid === 1'b1) got = 1'b1;
      else tick();
    end
    assertions++; if (!got) begin failures++; $display("FAIL fault_setup_timeout: got no valid required valid within 10 cycles"); end
    i_Ready = 1'b1;
    i_Flush = 1'b1;
    flushTarget = 32'h0000_0003;
    tick();
    assertions++; if ({o_Valid, o_MemRequest, o_FetchCount} !== {2'b00, expCount}) begin failures++; $display("FAIL hold_flush: got v=%b req=%b count=%0d required 0/0/%0d", o_Valid, o_MemRequest, o_FetchCount, expCount); end
    tick();
    for (int i = 0; i < 10; i++) begin
      assertions++;
      if ({o_Fault, o_MemRequest} !== 2'b10) begin failures++; $display("FAIL fault_hold[%0d]: got fault=%b req=%b required 1/0", i, o_Fault, o_MemRequest); end
      tick();
    end
    i_Flush = 1'b1;
    flushTarget = 32'h0000_0000;
    tick();
    assertions++; if ({o_Fault, o_MemRequest, o_MemAddress} !== {2'b01, 32'h0}) begin failures++; $display("FAIL fault_clear: got fault=%b req=%b %h required 0/1/00000000", o_Fault, o_MemRequest, o_MemAddress); end
  endtask

  task automatic test_reset_midflight();
    latency = 3;
    tick();
    i_Reset = 1'b1;
    ptr = 32'h0000_1000;
    tick();
    assertions++; if ({o_MemRequest, o_FetchCount} !== {1'b0, 16'h0}) begin failures++; $display("FAIL midreset_idle: got req=%b count=%0d required 0/0", o_MemRequest, o_FetchCount); end
    tick();
    assertions++; if ({o_Valid, o_MemRequest, o_MemAddress} !== {2'b01, 32'h0000_1000}) begin failures++; $display("FAIL midreset_req: got v=%b req=%b %h required 0/1/00001000", o_Valid, o_MemRequest, o_MemAddress); end
    for (int i = 0; i < 12 && expCount != 16'd1; i++) tick();
    assertions++; if (o_FetchCount !== 16'd1) begin failures++; $display("FAIL midreset_deliver: got count=%0d required 1", o_FetchCount); end
  endtask

  task automatic test_wrap();
    latency = 1;
    i_Ready = 1'b1;
    // Preload the counter just below its wrap point instead of 65k fetches.
    force dut.r_FetchCount = 16'hFFFE;
    #1;
    release dut.r_FetchCount;
    expCount = 16'hFFFE;
    #1;
    assertions++; if (o_FetchCount !== 16'hFFFE) begin failures++; $display("FAIL wrap_preload: got %h required fffe", o_FetchCount); end
    for (int i = 0; i < 30 && expCount != 16'h0001; i++) tick();
    assertions++; if (o_FetchCount !== 16'h0001) begin failures++; $display("FAIL wrap_final: got %h required 0001", o_FetchCount); end
  endtask

  initial begin
    assertions  = 0;
    failures    = 0;
    cycle       = 0;
    latency     = 1;
    pend        = 1'b0;
    pendStale   = 1'b0;
    pendRem     = 0;
    pendAddr    = 32'h0;
    curStale    = 1'b0;
    curAddr     = 32'h0;
    expCount    = 16'h0;
    i_Reset     = 1'b1;
    i_Flush     = 1'b0;
    i_Ready     = 1'b1;
    i_MemValid  = 1'b0;
    i_MemData   = 32'h0;
    ptr         = 32'h0040_0000;
    i_Address   = ptr;
    flushTarget = 32'h0;
    memWords[32'h0040_0000] = 32'h0000_0513;
    memWords[32'h0040_0004] = 32'h0000_4501;
    test_reset();
    test_basic();
    test_compressed();
    test_hold_stall();
    test_flush_wait();
    test_fault();
    test_reset_midflight();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion required finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
